// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID latch, 32x32 register file with same-cycle write
// bypass, branch/jump resolution in ID, load-use stall detection and the ID/EX register.
module id_stage #(
    parameter logic [4:0] LINK_REG = 5'd31
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Ins,
    input  logic [31:0] nextPC,
    input  logic        WB_WE,
    input  logic [4:0]  WB_Addr,
    input  logic [31:0] WB_Data,
    output logic [1:0]  bout,
    output logic [31:0] newPC,
    output logic        EX_Valid,
    output logic        EX_RegWrite,
    output logic        EX_MemRead,
    output logic        EX_MemWrite,
    output logic [31:0] EX_RD1,
    output logic [31:0] EX_RD2,
    output logic [31:0] EX_Imm,
    output logic [31:0] EX_LinkPC,
    output logic [5:0]  EX_Op,
    output logic [5:0]  EX_Funct,
    output logic [4:0]  EX_Shamt,
    output logic [4:0]  EX_Dst
);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D, OP_LUI  = 6'h0F, OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B, FN_JR   = 6'h08;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] link_pc;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [4:0]  dst;
    } idex_t;

    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc4_q, if_pc4_d;
    idex_t       idex_q, idex_d, dec;
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [31:0] rd1, rd2, imm_sext, imm_ext, target;
    logic        wb_hit, redirect, load_use;

    assign op     = if_instr_q[31:26];
    assign rs     = if_instr_q[25:21];
    assign rt     = if_instr_q[20:16];
    assign rd     = if_instr_q[15:11];
    assign shamt  = if_instr_q[10:6];
    assign funct  = if_instr_q[5:0];
    assign imm16  = if_instr_q[15:0];
    assign imm_sext = {{16{imm16[15]}}, imm16};

    // Register 0 is never written, so its storage stays zero and needs no read mux.
    assign wb_hit = WB_WE && (WB_Addr != 5'd0);
    assign rd1    = (wb_hit && WB_Addr == rs) ? WB_Data : rf_q[rs];
    assign rd2    = (wb_hit && WB_Addr == rt) ? WB_Data : rf_q[rt];

    assign load_use = idex_q.valid && idex_q.mem_read && (idex_q.dst != 5'd0) &&
                      ((idex_q.dst == rs) || (idex_q.dst == rt));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        imm_ext  = imm_sext;
        redirect = 1'b0;
        target   = {if_pc4_q[31:28], if_instr_q[25:0], 2'b00};
        dec      = '0;
        dec.valid     = 1'b1;
        dec.mem_read  = (op == OP_LW);
        dec.mem_write = (op == OP_SW);
        dec.rd1       = rd1;
        dec.rd2       = rd2;
        dec.link_pc   = if_pc4_q;
        dec.op        = op;
        dec.funct     = funct;
        dec.shamt     = shamt;

        case (op)
            OP_ANDI, OP_ORI: imm_ext = {16'h0000, imm16};
            OP_LUI:          imm_ext = {imm16, 16'h0000};
            default:         imm_ext = imm_sext;
        endcase
        dec.imm = imm_ext;

        case (op)
            OP_RTYPE: begin
                dec.dst       = rd;
                dec.reg_write = (funct != FN_JR);
            end
            OP_JAL: begin
                dec.dst       = LINK_REG;
                dec.reg_write = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW: begin
                dec.dst       = rt;
                dec.reg_write = 1'b1;
            end
            default: ;
        endcase

        case (op)
            OP_BEQ:   begin redirect = (rd1 == rd2); target = if_pc4_q + {imm_sext[29:0], 2'b00}; end
            OP_BNE:   begin redirect = (rd1 != rd2); target = if_pc4_q + {imm_sext[29:0], 2'b00}; end
            OP_J, OP_JAL: redirect = 1'b1;
            OP_RTYPE: if (funct == FN_JR) begin redirect = 1'b1; target = rd1; end
            default: ;
        endcase
    end

    // Reset forces sequential fetch even if a stale valid entry is still latched.
    always_comb begin
        bout   = 2'b01;
        newPC  = nextPC;
        idex_d = '0;
        if (RST && if_valid_q) begin
            if (load_use) begin
                bout = 2'b00;
            end else begin
                idex_d = dec;
                if (redirect) begin
                    bout  = 2'b10;
                    newPC = target;
                end
            end
        end
    end

    always_comb begin
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc4_d   = if_pc4_q;
        case (bout)
            2'b01: begin
                if_valid_d = 1'b1;
                if_instr_d = Ins;
                if_pc4_d   = nextPC;
            end
            2'b10:   if_valid_d = 1'b0;
            default: ;
        endcase

        rf_d = rf_q;
        if (wb_hit) rf_d[WB_Addr] = WB_Data;
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc4_q   <= '0;
            idex_q     <= '0;
            // NOTE: the register file is reset on purpose: every register must read zero after reset.
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc4_q   <= if_pc4_d;
            idex_q     <= idex_d;
            rf_q       <= rf_d;
        end
    end

    assign EX_Valid    = idex_q.valid;
    assign EX_RegWrite = idex_q.reg_write;
    assign EX_MemRead  = idex_q.mem_read;
    assign EX_MemWrite = idex_q.mem_write;
    assign EX_RD1      = idex_q.rd1;
    assign EX_RD2      = idex_q.rd2;
    assign EX_Imm      = idex_q.imm;
    assign EX_LinkPC   = idex_q.link_pc;
    assign EX_Op       = idex_q.op;
    assign EX_Funct    = idex_q.funct;
    assign EX_Shamt    = idex_q.shamt;
    assign EX_Dst      = idex_q.dst;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: single-instruction decode table, hand-written
// hazard/redirect/reset sequences, and random traffic against a behavioural model.
module tb_id_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] Ins = '0;
    logic [31:0] nextPC = '0;
    logic        WB_WE = 1'b0;
    logic [4:0]  WB_Addr = '0;
    logic [31:0] WB_Data = '0;
    logic [1:0]  bout;
    logic [31:0] newPC, EX_RD1, EX_RD2, EX_Imm, EX_LinkPC;
    logic        EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite;
    logic [5:0]  EX_Op, EX_Funct;
    logic [4:0]  EX_Shamt, EX_Dst;

    id_stage #(.LINK_REG(5'd31)) dut (
        .CLK(CLK), .RST(RST), .Ins(Ins), .nextPC(nextPC),
        .WB_WE(WB_WE), .WB_Addr(WB_Addr), .WB_Data(WB_Data),
        .bout(bout), .newPC(newPC),
        .EX_Valid(EX_Valid), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
        .EX_MemWrite(EX_MemWrite), .EX_RD1(EX_RD1), .EX_RD2(EX_RD2), .EX_Imm(EX_Imm),
        .EX_LinkPC(EX_LinkPC), .EX_Op(EX_Op), .EX_Funct(EX_Funct),
        .EX_Shamt(EX_Shamt), .EX_Dst(EX_Dst)
    );

    always #5 CLK = ~CLK;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b0; WB_WE = 1'b0; Ins = '0; nextPC = 32'h0000_0F00;
        mid();
        check("reset_bout", 32'(bout), 32'h1);
        check("reset_newpc", newPC, 32'h0000_0F00);
        tick();
        RST = 1'b1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        Ins = '0; WB_WE = 1'b1; WB_Addr = a; WB_Data = d;
        tick();
        WB_WE = 1'b0;
    endtask

    // ---------------- decode table ----------------
    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc4;
        logic [4:0]  dst;
        logic [31:0] imm;
        logic        rw, mr, mw;
        logic [1:0]  bout;
        logic [31:0] newpc;
    } vec_t;

    localparam logic [31:0] NP = 32'h1234_0000;
    vec_t vecs [16];

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        valid, rw, mr, mw;
        logic [31:0] rd1, rd2, imm, link;
        logic [5:0]  op, funct;
        logic [4:0]  shamt, dst;
    } ex_rec_t;

    logic [31:0] m_rf [32];
    logic        m_ifv;
    logic [31:0] m_ifi, m_ifp;
    ex_rec_t     m_ex;

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
        if (WB_WE && WB_Addr == r) return WB_Data;
        return m_rf[r];
    endfunction

    task automatic m_reset();
        m_ifv = 1'b0; m_ifi = '0; m_ifp = '0; m_ex = '0;
        foreach (m_rf[i]) m_rf[i] = '0;
    endtask

    task automatic model_comb(output logic [1:0] eb, output logic [31:0] enp, output ex_rec_t nx);
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd;
        logic [31:0] a, b, sx;
        op = m_ifi[31:26]; fn = m_ifi[5:0];
        rs = m_ifi[25:21]; rt = m_ifi[20:16]; rd = m_ifi[15:11];
        a  = m_read(rs);   b  = m_read(rt);
        sx = 32'($signed(m_ifi[15:0]));
        eb = 2'b01; enp = nextPC; nx = '0;
        if (RST && m_ifv) begin
            if (m_ex.valid && m_ex.mr && m_ex.dst != 0 && (m_ex.dst == rs || m_ex.dst == rt)) begin
                eb = 2'b00;
            end else begin
                nx.valid = 1'b1; nx.rd1 = a; nx.rd2 = b; nx.link = m_ifp;
                nx.op = op; nx.funct = fn; nx.shamt = m_ifi[10:6];
                if (op == 6'h0C || op == 6'h0D) nx.imm = 32'(m_ifi[15:0]);
                else if (op == 6'h0F)           nx.imm = 32'(m_ifi[15:0]) << 16;
                else                            nx.imm = sx;
                case (op)
                    6'h00: begin nx.dst = rd; nx.rw = (fn != 6'h08); end
                    6'h03: begin nx.dst = 5'd31; nx.rw = 1'b1; end
                    6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23: begin nx.dst = rt; nx.rw = 1'b1; end
                    default: ;
                endcase
                nx.mr = (op == 6'h23);
                nx.mw = (op == 6'h2B);
                if ((op == 6'h04 && a == b) || (op == 6'h05 && a != b)) begin
                    eb = 2'b10; enp = m_ifp + sx * 4;
                end
                if (op == 6'h02 || op == 6'h03) begin
                    eb = 2'b10; enp = (m_ifp & 32'hF000_0000) | (32'(m_ifi[25:0]) << 2);
                end
                if (op == 6'h00 && fn == 6'h08) begin
                    eb = 2'b10; enp = a;
                end
            end
        end
    endtask

    task automatic model_update(input logic rst_cur, input logic [1:0] eb, input ex_rec_t nx);
        if (!rst_cur) begin
            m_reset();
        end else begin
            if (WB_WE && WB_Addr != 0) m_rf[WB_Addr] = WB_Data;
            if (eb == 2'b01) begin m_ifv = 1'b1; m_ifi = Ins; m_ifp = nextPC; end
            else if (eb == 2'b10) m_ifv = 1'b0;
            m_ex = nx;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [31:0] r;
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        imm = 16'($urandom());
        case ($urandom_range(0, 15))
            0, 1:    r = {6'h00, rs, rt, rd, 5'($urandom_range(0, 31)), 6'h20};
            2:       r = {6'h00, rs, 15'h0, 6'h08};
            3:       r = {6'h08, rs, rt, imm};
            4:       r = {6'h09, rs, rt, imm};
            5:       r = {6'h0A, rs, rt, imm};
            6:       r = {6'h0C, rs, rt, imm};
            7:       r = {6'h0D, rs, rt, imm};
            8:       r = {6'h0F, rs, rt, imm};
            9, 10:   r = {6'h23, rs, rt, imm};
            11:      r = {6'h2B, rs, rt, imm};
            12:      r = {6'h04, rs, rt, imm};
            13:      r = {6'h05, rs, rt, imm};
            14:      r = {($urandom_range(0, 1) != 0) ? 6'h02 : 6'h03, 26'($urandom())};
            default: r = {6'h20, rs, rt, imm};
        endcase
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0]  eb;
        logic [31:0] enp;
        ex_rec_t     nx;
        logic        rst_cur;

        vecs[0]  = '{32'h2001_0005, 32'h0000_0004, 5'd1,  32'h0000_0005, 1'b1, 1'b0, 1'b0, 2'b01, NP};
        vecs[1]  = '{32'h2062_FFFF, 32'h0000_0004, 5'd2,  32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 2'b01, NP};
        vecs[2]  = '{32'h30A4_8000, 32'h0000_0004, 5'd4,  32'h0000_8000, 1'b1, 1'b0, 1'b0, 2'b01, NP};
        vecs[3]  = '{32'h3406_FFFF, 32'h0000_0004, 5'd6,  32'h0000_FFFF, 1'b1, 1'b0, 1'b0, 2'b01, NP};
        vecs[4]  = '{32'h3C07_1234, 32'h0000_0004, 5'd7,  32'h1234_0000, 1'b1, 1'b0, 1'b0, 2'b01, NP};
        vecs[5]  = '{32'h8C25_FFFC, 32'h0000_0004, 5'd5,  32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 2'b01, NP};
        vecs[6]  = '{32'hAC25_0008, 32'h0000_0004, 5'd0,  32'h0000_0008, 1'b0, 1'b0, 1'b1, 2'b01, NP};
        vecs[7]  = '{32'h012A_4020, 32'h0000_0004, 5'd8,  32'h0000_4020, 1'b1, 1'b0, 1'b0, 2'b01, NP};
        vecs[8]  = '{32'h0002_19C0, 32'h0000_0004, 5'd3,  32'h0000_19C0, 1'b1, 1'b0, 1'b0, 2'b01, NP};
        vecs[9]  = '{32'h1000_0003, 32'h0000_0010, 5'd0,  32'h0000_0003, 1'b0, 1'b0, 1'b0, 2'b10, 32'h0000_001C};
        vecs[10] = '{32'h1400_FFFE, 32'h0000_0100, 5'd0,  32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 2'b01, NP};
        vecs[11] = '{32'h1000_FFF8, 32'h0000_0010, 5'd0,  32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0, 2'b10, 32'hFFFF_FFF0};
        vecs[12] = '{32'h0810_0000, 32'hA000_0004, 5'd0,  32'h0000_0000, 1'b0, 1'b0, 1'b0, 2'b10, 32'hA040_0000};
        vecs[13] = '{32'h0C00_0040, 32'h0000_0008, 5'd31, 32'h0000_0040, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0100};
        vecs[14] = '{32'h0000_0008, 32'h0000_0020, 5'd0,  32'h0000_0008, 1'b0, 1'b0, 1'b0, 2'b10, 32'h0000_0000};
        vecs[15] = '{32'hFC00_0000, 32'h0000_0004, 5'd0,  32'h0000_0000, 1'b0, 1'b0, 1'b0, 2'b01, NP};

        for (int i = 0; i < 16; i++) begin
            do_reset();
            check($sformatf("v%0d_post_reset_valid", i), 32'(EX_Valid), 32'h0);
            Ins = vecs[i].ins; nextPC = vecs[i].pc4;
            mid();
            check($sformatf("v%0d_empty_bout", i), 32'(bout), 32'h1);
            tick();
            Ins = '0; nextPC = NP;
            mid();
            check($sformatf("v%0d_bout", i), 32'(bout), 32'(vecs[i].bout));
            check($sformatf("v%0d_newpc", i), newPC, vecs[i].newpc);
            tick();
            check($sformatf("v%0d_ctrl", i), {28'h0, EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite},
                  {28'h0, 1'b1, vecs[i].rw, vecs[i].mr, vecs[i].mw});
            check($sformatf("v%0d_dst", i), 32'(EX_Dst), 32'(vecs[i].dst));
            check($sformatf("v%0d_imm", i), EX_Imm, vecs[i].imm);
            check($sformatf("v%0d_link", i), EX_LinkPC, vecs[i].pc4);
            check($sformatf("v%0d_op_funct", i), {20'h0, EX_Op, EX_Funct},
                  {20'h0, vecs[i].ins[31:26], vecs[i].ins[5:0]});
        end

        // Write-back bypass into operand read, and writes to $0 ignored.
        do_reset();
        Ins = 32'h0060_2020; nextPC = 32'h4; tick();
        Ins = 32'h0003_2020; nextPC = 32'h8;
        WB_WE = 1'b1; WB_Addr = 5'd3; WB_Data = 32'hDEAD_BEEF;
        tick();
        check("bypass_rd1", EX_RD1, 32'hDEAD_BEEF);
        check("bypass_dst", 32'(EX_Dst), 32'd4);
        Ins = 32'h0000_2020; nextPC = 32'hC;
        WB_WE = 1'b1; WB_Addr = 5'd0; WB_Data = 32'hFFFF_FFFF;
        tick();
        WB_WE = 1'b0;
        check("rf_written_rd2", EX_RD2, 32'hDEAD_BEEF);
        check("r0_bypass_blocked", EX_RD1, 32'h0);
        tick();
        check("r0_still_zero", EX_RD1, 32'h0);

        // BEQ taken / not taken, with squash of the fetched instruction.
        do_reset();
        wb_write(5'd1, 32'd7);
        wb_write(5'd2, 32'd7);
        Ins = 32'h1022_0003; nextPC = 32'h10; tick();
        Ins = 32'h2001_0005; nextPC = 32'h14;
        mid();
        check("beq_taken_bout", 32'(bout), 32'h2);
        check("beq_taken_target", newPC, 32'h1C);
        tick();
        check("beq_issued_ctrl", {30'h0, EX_Valid, EX_RegWrite}, 32'h2);
        Ins = '0; nextPC = 32'h1C;
        mid();
        check("after_redirect_bout", 32'(bout), 32'h1);
        check("after_redirect_newpc", newPC, 32'h1C);
        tick();
        check("squashed_bubble", 32'(EX_Valid), 32'h0);
        wb_write(5'd2, 32'd8);
        Ins = 32'h1022_0003; nextPC = 32'h10; tick();
        Ins = '0; nextPC = 32'h14;
        mid();
        check("beq_not_taken_bout", 32'(bout), 32'h1);
        check("beq_not_taken_newpc", newPC, 32'h14);
        tick();

        // Load-use stall: exactly one bubble, then the dependent ADD issues.
        do_reset();
        Ins = 32'h8C05_0000; nextPC = 32'h4; tick();
        Ins = 32'h00A5_3020; nextPC = 32'h8; tick();
        check("lw_issued_memread", {27'h0, EX_MemRead, EX_Dst}, {27'h0, 1'b1, 5'd5});
        Ins = 32'h3C07_1234; nextPC = 32'hC;
        mid();
        check("stall_bout", 32'(bout), 32'h0);
        check("stall_newpc", newPC, 32'hC);
        tick();
        check("stall_bubble", 32'(EX_Valid), 32'h0);
        mid();
        check("post_stall_bout", 32'(bout), 32'h1);
        tick();
        check("add_after_stall", {26'h0, EX_Valid, EX_Dst}, {26'h0, 1'b1, 5'd6});
        mid();
        check("held_fetch_next_bout", 32'(bout), 32'h1);
        tick();
        check("held_fetch_decoded", 32'(EX_Dst), 32'd7);
        do_reset();
        Ins = 32'h8C05_0000; nextPC = 32'h4; tick();
        Ins = 32'h00E7_3020; nextPC = 32'h8; tick();
        Ins = '0;
        mid();
        check("no_stall_unrelated_bout", 32'(bout), 32'h1);
        tick();
        check("no_stall_unrelated_issue", {26'h0, EX_Valid, EX_Dst}, {26'h0, 1'b1, 5'd6});

        // JR through the register file and through the write-back bypass.
        do_reset();
        wb_write(5'd31, 32'h8);
        Ins = 32'h03E0_0008; nextPC = 32'h40; tick();
        Ins = '0; nextPC = 32'h44;
        mid();
        check("jr_bout", 32'(bout), 32'h2);
        check("jr_target", newPC, 32'h8);
        tick();
        Ins = 32'h03E0_0008; nextPC = 32'h50; tick();
        Ins = '0; WB_WE = 1'b1; WB_Addr = 5'd31; WB_Data = 32'h200;
        mid();
        check("jr_bypass_target", newPC, 32'h200);
        tick();
        WB_WE = 1'b0;

        // Reset asserted in the middle of a load-use stall.
        do_reset();
        wb_write(5'd5, 32'h55);
        Ins = 32'h8C05_0000; nextPC = 32'h4; tick();
        Ins = 32'h00A5_3020; nextPC = 32'h8; tick();
        RST = 1'b0; nextPC = 32'hC;
        mid();
        check("rst_in_stall_bout", 32'(bout), 32'h1);
        check("rst_in_stall_newpc", newPC, 32'hC);
        tick();
        RST = 1'b1;
        check("rst_in_stall_bubble", 32'(EX_Valid), 32'h0);
        Ins = 32'h00A5_3020; nextPC = 32'h20;
        mid();
        check("after_rst_bout", 32'(bout), 32'h1);
        tick();
        check("after_rst_ifid_empty", 32'(EX_Valid), 32'h0);
        Ins = '0;
        mid();
        check("after_rst_no_stall", 32'(bout), 32'h1);
        tick();
        check("after_rst_issue", 32'(EX_Valid), 32'h1);
        check("after_rst_regs_zero", EX_RD1, 32'h0);

        // Random traffic against the behavioural model.
        do_reset();
        m_reset();
        for (int c = 0; c < 1500; c++) begin
            RST     = ($urandom_range(0, 49) != 0);
            Ins     = rand_instr();
            nextPC  = $urandom() & 32'hFFFF_FFFC;
            WB_WE   = ($urandom_range(0, 1) != 0);
            WB_Addr = 5'($urandom_range(0, 7));
            WB_Data = $urandom();
            rst_cur = RST;
            mid();
            model_comb(eb, enp, nx);
            check($sformatf("rnd%0d_bout", c), 32'(bout), 32'(eb));
            check($sformatf("rnd%0d_newpc", c), newPC, enp);
            tick();
            model_update(rst_cur, eb, nx);
            check($sformatf("rnd%0d_ctrl", c), {28'h0, EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite},
                  {28'h0, m_ex.valid, m_ex.rw, m_ex.mr, m_ex.mw});
            check($sformatf("rnd%0d_rd1", c), EX_RD1, m_ex.rd1);
            check($sformatf("rnd%0d_rd2", c), EX_RD2, m_ex.rd2);
            check($sformatf("rnd%0d_imm", c), EX_Imm, m_ex.imm);
            check($sformatf("rnd%0d_link", c), EX_LinkPC, m_ex.link);
            check($sformatf("rnd%0d_fields", c), {10'h0, EX_Op, EX_Funct, EX_Shamt, EX_Dst},
                  {10'h0, m_ex.op, m_ex.funct, m_ex.shamt, m_ex.dst});
        end
        RST = 1'b1;
        WB_WE = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter LINK_REG, default 5'd31, destination register written by JAL.
REQ-002 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-003 RST  input  1  synchronous, active-low reset (RST==0 at posedge resets).
REQ-004 Ins  input  32  instruction fetched at current IF PC.
REQ-005 nextPC  input  32  IF PC+4.
REQ-006 WB_WE / WB_Addr / WB_Data  input  1/5/32  register-file write port from writeback.
REQ-007 bout  output  2  PC control to IF: 2'b01 sequential, 2'b10 redirect, 2'b00 hold; 2'b11 never driven.
REQ-008 newPC  output  32  PC IF loads when bout!=00.
REQ-009 EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite  output  1 each  registered ID/EX controls.
REQ-010 EX_RD1, EX_RD2, EX_Imm, EX_LinkPC  output  32 each  registered operands, extended immediate, link address.
REQ-011 EX_Op, EX_Funct  output  6 each; EX_Shamt, EX_Dst  output  5 each  registered decode fields.

Function
REQ-012 IF/ID latch (instr, pc4, valid) SHALL capture Ins/nextPC with valid=1 when bout==01, clear valid when bout==10, hold when bout==00.
REQ-013 Invalid IF/ID entry SHALL drive bout=01, newPC=nextPC, and a bubble into ID/EX.
REQ-014 Decode fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm=[15:0].
REQ-015 Immediate: zero-extended for ANDI(0C)/ORI(0D); imm<<16 for LUI(0F); sign-extended otherwise.
REQ-016 Destination: rd for op 00; LINK_REG for JAL(03); rt for 08,09,0A,0C,0D,0F,23; RegWrite=0 for SW(2B), BEQ(04), BNE(05), J(02), JR (op 00, funct 08), and unlisted opcodes.
REQ-017 MemRead=1 only for LW(23); MemWrite=1 only for SW(2B).
REQ-018 Register file: 32x32; write at posedge when WB_WE==1 and WB_Addr!=0; register 0 reads 0 always.
REQ-019 Read bypass: if WB_WE==1, WB_Addr!=0 and WB_Addr equals the read index, read value SHALL be WB_Data in the same cycle.
REQ-020 Branch resolution (combinational, valid entry, no stall): BEQ taken iff RD1==RD2, BNE iff RD1!=RD2; target=pc4+(sext(imm)<<2), 32-bit wrap.
REQ-021 J/JAL target={pc4[31:28], instr[25:0], 2'b00}; JR target=RD1 (bypassed value).
REQ-022 Taken branch or any jump: bout=10, newPC=target; else bout=01, newPC=nextPC; no delay slot, fetched instruction squashed per REQ-012.
REQ-023 JAL: EX_LinkPC=pc4, RegWrite=1, EX_Dst=LINK_REG; EX_LinkPC=pc4 for all other valid entries.
REQ-024 Load-use stall: if ID/EX holds EX_Valid=1, EX_MemRead=1, EX_Dst!=0 and EX_Dst equals current rs or rt, SHALL drive bout=00, newPC=nextPC, suppress branch resolution, insert bubble into ID/EX.
REQ-025 Stall lasts exactly one cycle per dependent load; after bubble, instruction re-decodes and proceeds.
REQ-026 Bubble: EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite=0; all data/field outputs=0.
REQ-027 Branches/jumps enter ID/EX with EX_Valid=1 (JAL carries link write); J/BEQ/BNE/JR carry RegWrite=0.

Reset
REQ-028 On RST==0: IF/ID valid=0, ID/EX=bubble, all 32 registers=0; reset dominates WB_WE in that cycle.
REQ-029 During reset and first cycle after, bout=01, newPC=nextPC (IF fetches from its reset PC).
REQ-030 Reset mid-stall or mid-redirect SHALL discard pending state; no stall persists past reset.

Verification
REQ-031 Reset release, Ins=ADDI $1,$0,5 (0x20010005) -> next cycle IF/ID valid; following cycle EX_Valid=1, EX_Dst=1, EX_Imm=5, EX_RegWrite=1.
REQ-032 WB_WE=1, WB_Addr=3, WB_Data=0xDEADBEEF same cycle as decode of ADD $4,$3,$0 -> EX_RD1=0xDEADBEEF; WB_Addr=0 write -> $0 still reads 0.
REQ-033 $1=$2=7, BEQ $1,$2,+3 at pc4=0x10 -> bout=10, newPC=0x1C, next IF/ID valid=0; with $2=8 -> bout=01.
REQ-034 LW $5,0($0) then ADD $6,$5,$5 -> one cycle bout=00 with EX_Valid=0, then ADD issues, bout=01; no stall if ADD uses $7.
REQ-035 JAL 0x40 at pc4=0x0000_0008 -> newPC=0x100, bout=10, EX_Dst=31, EX_LinkPC=0x8; JR $31 with $31=0x8 -> newPC=0x8.
REQ-036 RST=0 asserted during load-use stall -> next cycle EX_Valid=0, IF/ID valid=0, bout=01, registers read 0.
